// File: rtl/uart_rx_fifo_engine.sv
// UART receive engine: synchronised RX, half-bit start validation, configurable frame format,
// and a first-word-fall-through FIFO holding {parity error, framing error, data} per character.
module uart_rx_fifo_engine #(
  parameter int BAUD_W      = 19,
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [BAUD_W-1:0]          BAUD_K,
  input  logic [BAUD_W-1:0]          BAUD_KD2,
  input  logic                       EIGHT,
  input  logic                       PEN,
  input  logic                       OHEL,
  input  logic                       RX,
  input  logic                       RD,
  input  logic                       CLR,
  output logic                       RX_RDY,
  output logic [7:0]                 RX_DATA,
  output logic                       P_ERR,
  output logic                       F_ERR,
  output logic                       OVF,
  output logic                       BRK,
  output logic [$clog2(DEPTH+1)-1:0] FIFO_CNT
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [BAUD_W-1:0] ONE      = BAUD_W'(1);
  localparam logic [BAUD_W-1:0] TWO      = BAUD_W'(2);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state_reg, state_next;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                rxs_prev_reg;
  logic [BAUD_W-1:0]   timer_reg, timer_next;
  logic [3:0]          bit_cnt_reg, bit_cnt_next;
  logic [7:0]          data_reg, data_next;
  logic                par_reg, par_next;
  logic                eight_reg, eight_next;
  logic                pen_reg, pen_next;
  logic                ohel_reg, ohel_next;

  logic                rxs, fall, sample;
  logic [BAUD_W-1:0]   k_eff, kd2_eff;
  logic [3:0]          n_bits;
  logic                calc_par, perr;
  logic                wr_en, brk_set;
  logic [9:0]          wr_entry;

  logic [9:0]          mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                ovf_reg, brk_reg;
  logic                fifo_empty, fifo_full, rd_eff, wr_ok, ovf_set;
  logic [9:0]          head;

  assign rxs     = sync_reg[SYNC_STAGES-1];
  assign fall    = rxs_prev_reg & ~rxs;
  assign sample  = (timer_reg == ONE);
  assign k_eff   = (BAUD_K   < TWO) ? TWO : BAUD_K;
  assign kd2_eff = (BAUD_KD2 < TWO) ? TWO : BAUD_KD2;
  assign n_bits  = eight_reg ? 4'd8 : 4'd7;
  // In 7-bit mode data_reg[7] stays 0, so it never disturbs the parity reduction.
  assign calc_par = ohel_reg ? ~^data_reg : ^data_reg;
  assign perr     = pen_reg & (par_reg != calc_par);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_reg     <= '1;
      rxs_prev_reg <= 1'b1;
    end else begin
      sync_reg     <= {sync_reg[SYNC_STAGES-2:0], RX};
      rxs_prev_reg <= rxs;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      timer_reg   <= '0;
      bit_cnt_reg <= '0;
      data_reg    <= '0;
      par_reg     <= 1'b0;
      eight_reg   <= 1'b0;
      pen_reg     <= 1'b0;
      ohel_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      timer_reg   <= timer_next;
      bit_cnt_reg <= bit_cnt_next;
      data_reg    <= data_next;
      par_reg     <= par_next;
      eight_reg   <= eight_next;
      pen_reg     <= pen_next;
      ohel_reg    <= ohel_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    timer_next   = timer_reg;
    bit_cnt_next = bit_cnt_reg;
    data_next    = data_reg;
    par_next     = par_reg;
    eight_next   = eight_reg;
    pen_next     = pen_reg;
    ohel_next    = ohel_reg;
    wr_en        = 1'b0;
    wr_entry     = '0;
    brk_set      = 1'b0;
    if (state_reg != IDLE) timer_next = sample ? k_eff : timer_reg - ONE;
    case (state_reg)
      IDLE: begin
        if (fall) begin
          state_next   = START;
          timer_next   = kd2_eff;
          bit_cnt_next = '0;
          data_next    = '0;
          par_next     = 1'b0;
          eight_next   = EIGHT;
          pen_next     = PEN;
          ohel_next    = OHEL;
        end
      end
      START: begin
        if (sample) state_next = rxs ? IDLE : DATA;
      end
      DATA: begin
        if (sample) begin
          bit_cnt_next = bit_cnt_reg + 4'd1;
          if (bit_cnt_reg < n_bits) data_next[bit_cnt_reg[2:0]] = rxs;
          else                      par_next = rxs;
          if ((bit_cnt_reg == n_bits - 4'd1 && !pen_reg) || bit_cnt_reg == n_bits)
            state_next = STOP;
        end
      end
      STOP: begin
        if (sample) begin
          wr_en      = 1'b1;
          wr_entry   = {perr, ~rxs, data_reg};
          brk_set    = (data_reg == 8'h00) && !rxs && !(pen_reg && par_reg);
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign fifo_empty = (cnt_reg == '0);
  assign fifo_full  = (cnt_reg == FULL_CNT);
  assign rd_eff     = RD & ~fifo_empty;
  // A full FIFO still accepts the write when the head leaves in the same cycle.
  assign wr_ok      = wr_en & (~fifo_full | rd_eff);
  assign ovf_set    = wr_en & fifo_full & ~rd_eff;

  always_comb begin
    cnt_next = cnt_reg;
    case ({wr_ok, rd_eff})
      2'b10:   cnt_next = cnt_reg + CNT_W'(1);
      2'b01:   cnt_next = cnt_reg - CNT_W'(1);
      default: cnt_next = cnt_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_reg] <= wr_entry;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
      ovf_reg    <= 1'b0;
      brk_reg    <= 1'b0;
    end else begin
      if (wr_ok)  wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (rd_eff) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      cnt_reg <= cnt_next;
      if (ovf_set)  ovf_reg <= 1'b1;
      else if (CLR) ovf_reg <= 1'b0;
      if (brk_set)  brk_reg <= 1'b1;
      else if (CLR) brk_reg <= 1'b0;
    end
  end

  assign head     = mem[rd_ptr_reg];
  assign RX_RDY   = ~fifo_empty;
  assign RX_DATA  = fifo_empty ? 8'h00 : head[7:0];
  assign F_ERR    = fifo_empty ? 1'b0  : head[8];
  assign P_ERR    = fifo_empty ? 1'b0  : head[9];
  assign OVF      = ovf_reg;
  assign BRK      = brk_reg;
  assign FIFO_CNT = cnt_reg;

endmodule

// File: tb/tb_uart_rx_fifo_engine.sv
// Bench for uart_rx_fifo_engine: frames are driven on RX, expected FIFO entries are queued
// as {perr, ferr, data} and compared when the DUT presents them at the FIFO head.
module tb_uart_rx_fifo_engine;

  localparam int BAUD_W   = 19;
  localparam int DEPTH    = 8;
  localparam int BIT      = 16;
  localparam int IDLE_GAP = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [BAUD_W-1:0] BAUD_K = BAUD_W'(16);
  logic [BAUD_W-1:0] BAUD_KD2 = BAUD_W'(8);
  logic              EIGHT = 1'b1;
  logic              PEN = 1'b0;
  logic              OHEL = 1'b0;
  logic              RX = 1'b1;
  logic              RD = 1'b0;
  logic              CLR = 1'b0;
  logic              RX_RDY;
  logic [7:0]        RX_DATA;
  logic              P_ERR;
  logic              F_ERR;
  logic              OVF;
  logic              BRK;
  logic [3:0]        FIFO_CNT;

  int n_cmp = 0;
  int n_err = 0;
  logic [9:0] exp_q[$];

  uart_rx_fifo_engine #(.BAUD_W(BAUD_W), .DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .BAUD_K(BAUD_K), .BAUD_KD2(BAUD_KD2),
    .EIGHT(EIGHT), .PEN(PEN), .OHEL(OHEL), .RX(RX), .RD(RD), .CLR(CLR),
    .RX_RDY(RX_RDY), .RX_DATA(RX_DATA), .P_ERR(P_ERR), .F_ERR(F_ERR),
    .OVF(OVF), .BRK(BRK), .FIFO_CNT(FIFO_CNT)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input bit pbit_en,
                            input bit pbit, input bit stop);
    RX = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      RX = d[i];
      repeat (BIT) @(negedge clk);
    end
    if (pbit_en) begin
      RX = pbit;
      repeat (BIT) @(negedge clk);
    end
    RX = stop;
    repeat (BIT) @(negedge clk);
    RX = 1'b1;
    repeat (IDLE_GAP) @(negedge clk);
  endtask

  task automatic pop_check(input string tag);
    int n;
    logic [9:0] e;
    n = 0;
    while (!RX_RDY && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!RX_RDY) begin
      check_value({tag, "_rdy_timeout"}, 32'(RX_RDY), 32'd1);
      return;
    end
    if (exp_q.size() == 0) begin
      check_value({tag, "_unexpected_entry"}, 32'(exp_q.size()), 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check_value({tag, "_data"}, 32'(RX_DATA), 32'(e[7:0]));
    check_value({tag, "_ferr"}, 32'(F_ERR), 32'(e[8]));
    check_value({tag, "_perr"}, 32'(P_ERR), 32'(e[9]));
    RD = 1'b1;
    @(negedge clk);
    RD = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    repeat (3) @(negedge clk);
    check_value("rst_rdy",  32'(RX_RDY),   32'd0);
    check_value("rst_cnt",  32'(FIFO_CNT), 32'd0);
    check_value("rst_ovf",  32'(OVF),      32'd0);
    check_value("rst_brk",  32'(BRK),      32'd0);
    check_value("rst_data", 32'(RX_DATA),  32'd0);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // 8N1 basic character
    exp_q.push_back({1'b0, 1'b0, 8'hA5});
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
    check_value("a5_cnt", 32'(FIFO_CNT), 32'd1);
    check_value("a5_rdy", 32'(RX_RDY), 32'd1);
    pop_check("a5");
    check_value("a5_rdy_after_rd", 32'(RX_RDY), 32'd0);

    // 7-bit with parity, even then odd sense
    EIGHT = 1'b0; PEN = 1'b1; OHEL = 1'b0;
    exp_q.push_back({1'b1, 1'b0, 8'h41});
    send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1);
    exp_q.push_back({1'b0, 1'b0, 8'h41});
    send_frame(8'h41, 7, 1'b1, 1'b0, 1'b1);
    OHEL = 1'b1;
    exp_q.push_back({1'b0, 1'b0, 8'h41});
    send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1);
    check_value("7bit_cnt", 32'(FIFO_CNT), 32'd3);
    pop_check("7e1_bad_par");
    pop_check("7e1_good_par");
    pop_check("7o1_good_par");
    EIGHT = 1'b1; PEN = 1'b0; OHEL = 1'b0;

    // Framing error on non-zero data: no break
    exp_q.push_back({1'b0, 1'b1, 8'h3C});
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0);
    check_value("ferr_brk", 32'(BRK), 32'd0);
    pop_check("ferr_3c");

    // Break: line low for two frame times, single entry
    exp_q.push_back({1'b0, 1'b1, 8'h00});
    RX = 1'b0;
    repeat (2 * 10 * BIT) @(negedge clk);
    RX = 1'b1;
    repeat (IDLE_GAP) @(negedge clk);
    check_value("brk_flag", 32'(BRK), 32'd1);
    check_value("brk_cnt", 32'(FIFO_CNT), 32'd1);
    pop_check("brk_entry");
    CLR = 1'b1;
    @(negedge clk);
    CLR = 1'b0;
    check_value("brk_clr", 32'(BRK), 32'd0);

    // Short low glitch is rejected, then a normal frame is still received
    RX = 1'b0;
    repeat (4) @(negedge clk);
    RX = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    check_value("glitch_cnt", 32'(FIFO_CNT), 32'd0);
    exp_q.push_back({1'b0, 1'b0, 8'h96});
    send_frame(8'h96, 8, 1'b0, 1'b0, 1'b1);
    pop_check("after_glitch");

    // Overflow: DEPTH+1 characters without reading
    for (int k = 0; k < DEPTH + 1; k++) begin
      d = 8'($urandom_range(0, 255));
      if (k < DEPTH) exp_q.push_back({1'b0, 1'b0, d});
      send_frame(d, 8, 1'b0, 1'b0, 1'b1);
    end
    check_value("ovf_cnt", 32'(FIFO_CNT), 32'(DEPTH));
    check_value("ovf_flag", 32'(OVF), 32'd1);
    CLR = 1'b1;
    @(negedge clk);
    CLR = 1'b0;
    check_value("ovf_clr", 32'(OVF), 32'd0);

    // Write and RD in the same cycle while full: the write lands on clock 155 after start
    d = 8'hC3;
    fork
      send_frame(d, 8, 1'b0, 1'b0, 1'b1);
      begin
        logic [9:0] e;
        repeat (154) @(negedge clk);
        e = exp_q.pop_front();
        check_value("full_rw_head", 32'(RX_DATA), 32'(e[7:0]));
        RD = 1'b1;
        @(negedge clk);
        RD = 1'b0;
        check_value("full_rw_cnt", 32'(FIFO_CNT), 32'(DEPTH));
      end
    join
    exp_q.push_back({1'b0, 1'b0, d});
    check_value("full_rw_ovf", 32'(OVF), 32'd0);
    for (int k = 0; k < DEPTH; k++) pop_check($sformatf("drain%0d", k));
    check_value("drain_cnt", 32'(FIFO_CNT), 32'd0);

    // Reset mid-frame with a character already buffered
    exp_q.push_back({1'b0, 1'b0, 8'h11});
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1);
    RX = 1'b0;
    repeat (BIT + 3 * BIT) @(negedge clk);
    reset = 1'b0;
    #1;
    check_value("midrst_cnt", 32'(FIFO_CNT), 32'd0);
    check_value("midrst_rdy", 32'(RX_RDY), 32'd0);
    exp_q.delete();
    RX = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (IDLE_GAP) @(negedge clk);
    exp_q.push_back({1'b0, 1'b0, 8'h5A});
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1);
    check_value("post_rst_cnt", 32'(FIFO_CNT), 32'd1);
    pop_check("post_rst_5a");
    check_value("sb_leftover", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
